multiplicand_buffer: RTL and testbench

Parametrised multiplicand operand buffer for the sequential multiplier datapath. It replaces the single write-enabled multiplicand register with a DEPTH-entry first-word-fall-through queue. Each entry carries a per-operand signed/unsigned mode, and the head entry is presented sign- or zero-extended to WIDTH+1 bits. The multiplier control unit can therefore queue several operands while a multiplication is in progress and consume them one at a time.

---
 rtl/multiplicand_pkg.sv | 20 ++
 rtl/multiplicand_store.sv | 29 ++
 rtl/multiplicand_buffer.sv | 123 ++++++++++++
 tb/tb_multiplicand_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/multiplicand_pkg.sv
// Shared constants and types for the multiplicand operand buffer.
// The optional negated head output is built only when MULTIPLICAND_NEG_EN is defined.
package multiplicand_pkg;

  // Default operand width and queue depth for the sequential multiplier.
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 4;

  // One queued operand at the default width: its mode flag and raw data.
  typedef struct packed {
    logic                     isSigned;
    logic [DEFAULT_WIDTH-1:0] data;
  } entry_t;

  // Pointer width for a queue of the given depth; never narrower than one bit.
  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/multiplicand_store.sv
// Register array that holds the queued operands, each with its mode flag.
// One synchronous write port and a combinational read selected by the read pointer.
// Contents are never reset; only the pointers in the parent decide what is valid.
module multiplicand_store
  import multiplicand_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       i_wrEn,
  input  logic [ptrWidth(DEPTH)-1:0] i_wrPtr,
  input  logic [WIDTH:0]             i_wrData,
  input  logic [ptrWidth(DEPTH)-1:0] i_rdPtr,
  output logic [WIDTH:0]             o_rdData
);

  logic [WIDTH:0] r_mem [DEPTH];

  // Capture the incoming entry into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[i_wrPtr] <= i_wrData;
    end
  end

  assign o_rdData = r_mem[i_rdPtr];

endmodule

// File: rtl/multiplicand_buffer.sv
// First-word-fall-through multiplicand queue for the sequential multiplier.
// Each entry remembers whether it is signed; the head is presented extended to WIDTH+1 bits.
// Define MULTIPLICAND_NEG_EN to add Multiplicand_neg_out, the negated head for the subtract path.
module multiplicand_buffer
  import multiplicand_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     Reset_n,
  input  logic                     Clear,
  input  logic                     W_ctrl,
  input  logic [WIDTH-1:0]         Multiplicand_in,
  input  logic                     Signed_in,
  output logic                     W_ready,
  input  logic                     Pop,
  output logic                     Out_valid,
  output logic [WIDTH:0]           Multiplicand_out,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow
`ifdef MULTIPLICAND_NEG_EN
  ,
  output logic [WIDTH:0]           Multiplicand_neg_out
`endif
);

  localparam int PW = ptrWidth(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef struct packed {
    logic             isSigned;
    logic [WIDTH-1:0] data;
  } entryT;

  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic  w_notFull;
  logic  w_notEmpty;
  logic  w_push;
  logic  w_pop;
  entryT w_wrEntry;
  entryT w_head;

  assign w_notFull  = (r_count != CNT_FULL);
  assign w_notEmpty = (r_count != '0);
  assign w_push     = W_ctrl & w_notFull;
  assign w_pop      = Pop & w_notEmpty;

  assign w_wrEntry.isSigned = Signed_in;
  assign w_wrEntry.data     = Multiplicand_in;

  multiplicand_store #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_store (
    .clk      (clk),
    .i_wrEn   (w_push & ~Clear),
    .i_wrPtr  (r_wrPtr),
    .i_wrData (w_wrEntry),
    .i_rdPtr  (r_rdPtr),
    .o_rdData (w_head)
  );

  // Queue bookkeeping: Clear flushes everything, otherwise pointers advance on
  // accepted pushes/pops and a write against a full queue latches Overflow.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (Clear) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_ONE;
      end
      if (W_ctrl && !w_notFull) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign W_ready   = w_notFull;
  assign Out_valid = w_notEmpty;
  assign Count     = r_count;
  assign Overflow  = r_overflow;

  // Present the head operand extended by its own mode; an empty queue reads as zero.
  always_comb begin
    Multiplicand_out = '0;
    if (w_notEmpty) begin
      Multiplicand_out = {w_head.isSigned & w_head.data[WIDTH-1], w_head.data};
    end
  end

`ifdef MULTIPLICAND_NEG_EN
  localparam logic [WIDTH:0] ZERO_EXT = '0;

  // Negation wraps at WIDTH+1 bits, so an empty (zero) head negates to zero.
  assign Multiplicand_neg_out = ZERO_EXT - Multiplicand_out;
`endif

endmodule

// File: tb/tb_multiplicand_buffer.sv
// Self-checking bench for multiplicand_buffer with the default 32-bit, 4-deep configuration.
// A queue-based reference model tracks contents, occupancy and the sticky overflow flag.
module tb_multiplicand_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic        clk;
  logic        Reset_n;
  logic        Clear;
  logic        W_ctrl;
  logic [31:0] Multiplicand_in;
  logic        Signed_in;
  logic        W_ready;
  logic        Pop;
  logic        Out_valid;
  logic [32:0] Multiplicand_out;
  logic [2:0]  Count;
  logic        Overflow;
`ifdef MULTIPLICAND_NEG_EN
  logic [32:0] Multiplicand_neg_out;
`endif

  int checks = 0;
  int errors = 0;

  logic [32:0] modelQ [$];
  logic        modelOvf;

  multiplicand_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .Reset_n          (Reset_n),
    .Clear            (Clear),
    .W_ctrl           (W_ctrl),
    .Multiplicand_in  (Multiplicand_in),
    .Signed_in        (Signed_in),
    .W_ready          (W_ready),
    .Pop              (Pop),
    .Out_valid        (Out_valid),
    .Multiplicand_out (Multiplicand_out),
    .Count            (Count),
    .Overflow         (Overflow)
`ifdef MULTIPLICAND_NEG_EN
    ,
    .Multiplicand_neg_out (Multiplicand_neg_out)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Operand as the consumer should see it: sign bit copied only for signed entries.
  function automatic logic [32:0] extend(input logic [31:0] d, input logic s);
    return {s & d[31], d};
  endfunction

  function automatic logic [32:0] modelHead();
    return (modelQ.size() > 0) ? modelQ[0] : 33'h0;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, sample 1 time unit later.
  task automatic step(input logic w, input logic [31:0] d, input logic s,
                      input logic p, input logic c);
    int occ;
    W_ctrl = w; Multiplicand_in = d; Signed_in = s; Pop = p; Clear = c;
    @(posedge clk);
    occ = modelQ.size();
    if (c) begin
      modelQ.delete();
      modelOvf = 1'b0;
    end else begin
      if (w && occ == DEPTH) modelOvf = 1'b1;
      if (p && occ > 0) void'(modelQ.pop_front());
      if (w && occ < DEPTH) modelQ.push_back(extend(d, s));
    end
    #1;
    W_ctrl = 1'b0; Pop = 1'b0; Clear = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h00000042, 1'b0, 1'b0, 1'b0);
    #2 Reset_n = 1'b0;
    #1;
    modelQ.delete();
    modelOvf = 1'b0;
    checks++; if (Count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got %0d exp 0", Count); end
    checks++; if (Out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", Out_valid); end
    checks++; if (W_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b exp 1", W_ready); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b exp 0", Overflow); end
    checks++; if (Multiplicand_out !== 33'h0) begin errors++; $display("[TB] FAIL reset_out got %h exp 0", Multiplicand_out); end
`ifdef MULTIPLICAND_NEG_EN
    checks++; if (Multiplicand_neg_out !== 33'h0) begin errors++; $display("[TB] FAIL reset_neg got %h exp 0", Multiplicand_neg_out); end
`endif
    @(negedge clk);
    Reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_push();
    step(1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0);
    checks++; if (Out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %b exp 1", Out_valid); end
    checks++; if (Multiplicand_out !== 33'h012345678) begin errors++; $display("[TB] FAIL single_out got %h exp 012345678", Multiplicand_out); end
    checks++; if (Count !== 3'd1) begin errors++; $display("[TB] FAIL single_count got %0d exp 1", Count); end
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checks++; if (Out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drain got %b exp 0", Out_valid); end
  endtask

  task automatic test_sign_ext();
    step(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    checks++; if (Multiplicand_out !== 33'h1DEADBEEF) begin errors++; $display("[TB] FAIL signext_signed got %h exp 1deadbeef", Multiplicand_out); end
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checks++; if (Multiplicand_out !== 33'h0DEADBEEF) begin errors++; $display("[TB] FAIL signext_unsigned got %h exp 0deadbeef", Multiplicand_out); end
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_full_overflow();
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
      if (i == 4) begin
        checks++; if (W_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready got %b exp 0", W_ready); end
        checks++; if (Count !== 3'd4) begin errors++; $display("[TB] FAIL full_count got %0d exp 4", Count); end
        checks++; if (Overflow !== 1'b0) begin errors++; $display("[TB] FAIL full_ovf_early got %b exp 0", Overflow); end
      end
    end
    checks++; if (Overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got %b exp 1", Overflow); end
    checks++; if (Count !== 3'd4) begin errors++; $display("[TB] FAIL ovf_count got %0d exp 4", Count); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (Multiplicand_out !== 33'(i)) begin errors++; $display("[TB] FAIL drain_%0d got %h exp %h", i, Multiplicand_out, 33'(i)); end
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    end
    checks++; if (Out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_valid got %b exp 0", Out_valid); end
    checks++; if (Multiplicand_out !== 33'h0) begin errors++; $display("[TB] FAIL drain_out got %h exp 0", Multiplicand_out); end
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checks++; if (Count !== 3'd0) begin errors++; $display("[TB] FAIL empty_pop_count got %0d exp 0", Count); end
    checks++; if (Overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got %b exp 1", Overflow); end
  endtask

  task automatic test_push_pop_wrap();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, $urandom, 1'($urandom), 1'b0, 1'b0);
    step(1'b1, $urandom, 1'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      logic [32:0] expHead;
      expHead = modelHead();
      checks++; if (Multiplicand_out !== expHead) begin errors++; $display("[TB] FAIL wrap_head_%0d got %h exp %h", i, Multiplicand_out, expHead); end
      step(1'b1, $urandom, 1'($urandom), 1'b1, 1'b0);
      checks++; if (Count !== 3'd2) begin errors++; $display("[TB] FAIL wrap_count_%0d got %0d exp 2", i, Count); end
    end
  endtask

  task automatic test_clear();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checks++; if (Count !== 3'd3 || Overflow !== 1'b1) begin errors++; $display("[TB] FAIL preclear got count %0d ovf %b exp 3 1", Count, Overflow); end
    step(1'b1, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1);
    checks++; if (Count !== 3'd0) begin errors++; $display("[TB] FAIL clear_count got %0d exp 0", Count); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("[TB] FAIL clear_ovf got %b exp 0", Overflow); end
    checks++; if (Out_valid !== 1'b0) begin errors++; $display("[TB] FAIL clear_valid got %b exp 0", Out_valid); end
  endtask

`ifdef MULTIPLICAND_NEG_EN
  task automatic test_neg();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    checks++; if (Multiplicand_out !== 33'h0FFFFFFFF) begin errors++; $display("[TB] FAIL neg_out got %h exp 0ffffffff", Multiplicand_out); end
    checks++; if (Multiplicand_neg_out !== 33'h100000001) begin errors++; $display("[TB] FAIL neg_val got %h exp 100000001", Multiplicand_neg_out); end
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checks++; if (Multiplicand_out !== 33'h0) begin errors++; $display("[TB] FAIL neg_empty_out got %h exp 0", Multiplicand_out); end
    checks++; if (Multiplicand_neg_out !== 33'h0) begin errors++; $display("[TB] FAIL neg_empty_neg got %h exp 0", Multiplicand_neg_out); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [32:0] expHead;
      logic [2:0]  expCount;
      step(($urandom_range(0, 9) < 6), $urandom, 1'($urandom), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 31) == 0));
      expHead  = modelHead();
      expCount = 3'(modelQ.size());
      checks++; if (Multiplicand_out !== expHead) begin errors++; $display("[TB] FAIL rand_out_%0d got %h exp %h", i, Multiplicand_out, expHead); end
      checks++; if (Count !== expCount) begin errors++; $display("[TB] FAIL rand_count_%0d got %0d exp %0d", i, Count, expCount); end
      checks++; if (Out_valid !== (modelQ.size() > 0)) begin errors++; $display("[TB] FAIL rand_valid_%0d got %b", i, Out_valid); end
      checks++; if (W_ready !== (modelQ.size() < DEPTH)) begin errors++; $display("[TB] FAIL rand_ready_%0d got %b", i, W_ready); end
      checks++; if (Overflow !== modelOvf) begin errors++; $display("[TB] FAIL rand_ovf_%0d got %b exp %b", i, Overflow, modelOvf); end
`ifdef MULTIPLICAND_NEG_EN
      checks++; if (Multiplicand_neg_out !== 33'(-expHead)) begin errors++; $display("[TB] FAIL rand_neg_%0d got %h exp %h", i, Multiplicand_neg_out, 33'(-expHead)); end
`endif
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    Reset_n = 1'b0; Clear = 1'b0; W_ctrl = 1'b0; Pop = 1'b0;
    Multiplicand_in = '0; Signed_in = 1'b0;
    modelOvf = 1'b0;
    #12 Reset_n = 1'b1;
    test_reset();
    test_single_push();
    test_sign_ext();
    test_full_overflow();
    test_push_pop_wrap();
    test_clear();
`ifdef MULTIPLICAND_NEG_EN
    test_neg();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
